// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter
//   Shares one iterative divider between N_REQ requesters. A round-robin
//   arbiter picks one request while idle. That requester's operands are driven
//   onto the divider and held for LATENCY clocks. The quotient and remainder
//   are then captured and returned over a valid/ready response channel. A
//   zero divisor does not use the divider: it answers q = all ones and r = a.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req               per-requester request, held until its gnt bit pulses
//   a_in, b_in        packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt               one-hot, one-cycle pulse when operands are taken
//   div_a, div_b      operands to the shared divider
//   div_q, div_r      divider results, valid LATENCY clocks after load
//   rsp_valid/ready   response handshake
//   rsp_id/q/r        response payload: requester id, quotient, remainder
//   busy              high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module div_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 8,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       div_a,
    output logic [WIDTH-1:0]       div_b,
    input  logic [WIDTH-1:0]       div_q,
    input  logic [WIDTH-1:0]       div_r,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_q,
    output logic [WIDTH-1:0]       rsp_r,
    input  logic                   rsp_ready,
    output logic                   busy
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_REQ-1:0]   gnt_q;
    logic [WIDTH-1:0]   div_a_q;
    logic [WIDTH-1:0]   div_b_q;
    logic [WIDTH-1:0]   rsp_q_q;
    logic [WIDTH-1:0]   rsp_r_q;
    logic               rsp_valid_q;

    // Unpack the operand buses so the selected requester can be indexed.
    logic [WIDTH-1:0] a_arr [N_REQ];
    logic [WIDTH-1:0] b_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = a_in[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = b_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin pick: first set request bit at or above the pointer, wrapping.
    logic            pick_found;
    logic [ID_W-1:0] pick_id;
    logic [ID_W:0]   scan_idx;
    logic [ID_W-1:0] ptr_d;

    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(N_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(N_REQ);
            end
            if (!pick_found && req[scan_idx[ID_W-1:0]]) begin
                pick_found = 1'b1;
                pick_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    assign ptr_d = (pick_id == ID_W'(N_REQ-1)) ? '0 : pick_id + ID_W'(1);

    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    assign sel_a = a_arr[pick_id];
    assign sel_b = b_arr[pick_id];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            rsp_q_q     <= '0;
            rsp_r_q     <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            // Grant is a single-cycle pulse.
            gnt_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        gnt_q <= N_REQ'(1) << pick_id;
                        id_q  <= pick_id;
                        ptr_q <= ptr_d;
                        if (sel_b != '0) begin
                            div_a_q <= sel_a;
                            div_b_q <= sel_b;
                            cnt_q   <= '0;
                            state_q <= RUN;
                        end else begin
                            // Divide by zero: answer directly, keep the divider inputs unchanged.
                            rsp_q_q     <= '1;
                            rsp_r_q     <= sel_a;
                            rsp_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(LATENCY-1)) begin
                        rsp_q_q     <= div_q;
                        rsp_r_q     <= div_r;
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_r     = rsp_r_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

    localparam int N_REQ   = 4;
    localparam int WIDTH   = 8;
    localparam int LATENCY = 8;
    localparam int ID_W    = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       div_a;
    logic [WIDTH-1:0]       div_b;
    logic [WIDTH-1:0]       div_q;
    logic [WIDTH-1:0]       div_r;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_q;
    logic [WIDTH-1:0]       rsp_r;
    logic                   rsp_ready;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_arbiter #(
        .N_REQ(N_REQ), .WIDTH(WIDTH), .LATENCY(LATENCY), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .div_a(div_a), .div_b(div_b), .div_q(div_q), .div_r(div_r),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r),
        .rsp_ready(rsp_ready), .busy(busy)
    );

    // Divider model: results are correct only once the operands have been
    // stable long enough to be sampled at the LATENCY-th edge after loading;
    // before that it returns junk so an early capture is visible.
    logic [WIDTH-1:0] prev_a = '0;
    logic [WIDTH-1:0] prev_b = '0;
    int               age    = 0;

    always @(posedge clk) begin
        if (div_a != prev_a || div_b != prev_b) begin
            age    <= 0;
            prev_a <= div_a;
            prev_b <= div_b;
        end else if (age < 1000) begin
            age <= age + 1;
        end
    end

    always_comb begin
        div_q = 8'hA5;
        div_r = 8'h5A;
        if (age >= LATENCY-2 && div_b != 0) begin
            div_q = div_a / div_b;
            div_r = div_a % div_b;
        end
    end

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
    } vec_t;

    vec_t vecs [7];
    logic [7:0] last_a = '0;
    logic [7:0] last_b = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ops(input int id, input logic [7:0] a, input logic [7:0] b);
        a_in[id*WIDTH +: WIDTH] = a;
        b_in[id*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_gnt();
        int w;
        w = 0;
        tick();
        while (gnt == '0 && w < 20) begin
            tick();
            w++;
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int elat;
        elat = (v.b == 0) ? 0 : LATENCY;
        set_ops(v.id, v.a, v.b);
        req[v.id] = 1'b1;
        wait_gnt();
        chk("gnt_onehot", gnt, 32'(1) << v.id);
        req[v.id] = 1'b0;
        wait_valid(lat);
        chk("latency", lat, elat);
        chk("rsp_q", rsp_q, v.q);
        chk("rsp_r", rsp_r, v.r);
        chk("rsp_id", rsp_id, v.id);
        if (v.b == 0) begin
            chk("div_a_untouched", div_a, last_a);
            chk("div_b_untouched", div_b, last_b);
        end else begin
            chk("gnt_single_pulse", gnt, 0);
            last_a = v.a;
            last_b = v.b;
        end
        $display("txn id=%0d a=%0d b=%0d -> q=%0d r=%0d lat=%0d", v.id, v.a, v.b, rsp_q, rsp_r, lat);
        tick();
        chk("valid_after_hs", rsp_valid, 0);
        chk("busy_after_hs", busy, 0);
    endtask

    initial begin
        int lat;
        int order [5];

        vecs[0] = '{0,  14,   3,  4,  2};
        vecs[1] = '{1,  24,   3,  8,  0};
        vecs[2] = '{2, 100,  12,  8,  4};
        vecs[3] = '{3,  77,   0, 8'hFF, 77};
        vecs[4] = '{1, 200,   7, 28,  4};
        vecs[5] = '{0, 255,   1, 255, 0};
        vecs[6] = '{2,   5,   9,  0,  5};
        order   = '{0, 1, 2, 3, 0};

        rst_n     = 1'b0;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_div_a", div_a, 0);
        chk("rst_div_b", div_b, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_q", rsp_q, 0);
        chk("rst_r", rsp_r, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();

        // Single requests, including the divide-by-zero bypass.
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Back-pressure: response held, new request parked until handshake.
        rsp_ready = 1'b0;
        set_ops(0, 14, 3);
        req[0] = 1'b1;
        wait_gnt();
        chk("bp_gnt", gnt, 4'b0001);
        req[0] = 1'b0;
        wait_valid(lat);
        chk("bp_latency", lat, LATENCY);
        set_ops(1, 50, 5);
        req[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_valid_held", rsp_valid, 1);
            chk("bp_q_held", rsp_q, 4);
            chk("bp_r_held", rsp_r, 2);
            chk("bp_id_held", rsp_id, 0);
            chk("bp_busy", busy, 1);
            chk("bp_no_gnt", gnt, 0);
        end
        $display("txn backpressure id=0 q=%0d r=%0d held 5 clks", rsp_q, rsp_r);
        rsp_ready = 1'b1;
        tick();
        chk("bp_hs_valid", rsp_valid, 0);
        tick();
        chk("bp_next_gnt", gnt, 4'b0010);
        req[1] = 1'b0;
        wait_valid(lat);
        chk("bp_next_q", rsp_q, 10);
        chk("bp_next_r", rsp_r, 0);
        chk("bp_next_id", rsp_id, 1);
        $display("txn id=1 a=50 b=5 -> q=%0d r=%0d", rsp_q, rsp_r);
        tick();

        // Reset in the middle of RUN abandons the operation.
        set_ops(2, 9, 2);
        req[2] = 1'b1;
        wait_gnt();
        chk("mr_gnt", gnt, 4'b0100);
        req[2] = 1'b0;
        tick();
        tick();
        tick();
        chk("mr_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_div_a", div_a, 0);
        chk("mr_div_b", div_b, 0);
        chk("mr_valid", rsp_valid, 0);
        chk("mr_id", rsp_id, 0);
        chk("mr_gnt0", gnt, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) tick();
        chk("mr_no_rsp", rsp_valid, 0);
        chk("mr_idle", busy, 0);
        $display("txn reset mid-run, operation dropped");

        // All four requesters active: strict round robin from pointer 0.
        for (int i = 0; i < N_REQ; i++) set_ops(i, 8, 4);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt();
            chk("rr_gnt", gnt, 32'(1) << order[k]);
            req[order[k]] = 1'b0;
            wait_valid(lat);
            chk("rr_latency", lat, LATENCY);
            chk("rr_id", rsp_id, order[k]);
            chk("rr_q", rsp_q, 2);
            chk("rr_r", rsp_r, 0);
            $display("txn rr grant=%0d id=%0d q=%0d r=%0d", order[k], rsp_id, rsp_q, rsp_r);
            tick();
            if (k < 4) req[order[k]] = 1'b1;
        end
        req = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
